// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp block: default duty resolution and FSM states.
package pwm_pkg;

    localparam int unsigned R_DEFAULT = 8;

    typedef enum logic {
        IDLE,
        WAIT_DONE
    } pwm_state_t;

endpackage

// File: rtl/pwm_duty_ramp_stepper.sv
// Combinational next-duty computation: moves cur toward tgt by at most step, never past it.
module duty_stepper
    import pwm_pkg::*;
#(
    parameter int unsigned R = R_DEFAULT
) (
    input  logic [R:0] i_cur,
    input  logic [R:0] i_tgt,
    input  logic [R:0] i_step,
    output logic [R:0] o_next
);

    logic [R+1:0] w_cur;
    logic [R+1:0] w_tgt;
    logic [R+1:0] w_step;
    logic [R+1:0] w_up;
    logic [R+1:0] w_dn;

    assign w_cur  = {1'b0, i_cur};
    assign w_tgt  = {1'b0, i_tgt};
    assign w_step = {1'b0, i_step};
    assign w_up   = w_cur + w_step;
    assign w_dn   = w_cur - w_step;

    // One extra bit of headroom lets the sum and difference be compared without wrapping.
    always_comb begin
        o_next = i_tgt;
        if (i_step != '0) begin
            if (i_tgt > i_cur) begin
                o_next = (w_up > w_tgt) ? i_tgt : w_up[R:0];
            end else begin
                o_next = ((w_step > w_cur) || (w_dn < w_tgt)) ? i_tgt : w_dn[R:0];
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Ramps the PWM duty toward a captured target, one handshaked step at a time.
// Optional feature: define PWM_DUTY_CLAMP_EN to limit captured targets to DUTY_MAX.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned R        = R_DEFAULT,
    parameter int unsigned DUTY_MAX = 2 ** R
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [R:0] target,
    input  logic       target_valid,
    output logic       target_ack,
    input  logic [R:0] step_size,
    output logic [R:0] duty,
    output logic       ready,
    input  logic       done,
    output logic       busy,
    output logic       at_target
);

    localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};
`ifdef PWM_DUTY_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    localparam logic [R:0] CEIL = (CLAMP && (DUTY_MAX < 2 ** R)) ? DUTY_MAX[R:0] : FULL;

    pwm_state_t r_state;
    pwm_state_t w_state_nxt;
    logic [R:0] r_tgt;
    logic [R:0] r_cur;
    logic [R:0] r_duty;
    logic       r_ack;
    logic       r_at;
    logic [R:0] w_tgt_sat;
    logic [R:0] w_step;
    logic [R:0] w_tgt_nxt;
    logic [R:0] w_cur_nxt;
    logic       w_launch;
    logic       w_apply;

    assign w_tgt_sat = (target > CEIL) ? CEIL : target;

    duty_stepper #(
        .R(R)
    ) u_stepper (
        .i_cur (r_cur),
        .i_tgt (r_tgt),
        .i_step(step_size),
        .o_next(w_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && (r_cur != r_tgt)) begin
                    w_launch    = 1'b1;
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    w_apply     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_tgt_nxt = target_valid ? w_tgt_sat : r_tgt;
    assign w_cur_nxt = w_apply ? r_duty : r_cur;

    // at_target is registered from the post-edge values so it always matches cur_reg == tgt_reg.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tgt  <= '0;
            r_cur  <= '0;
            r_duty <= '0;
            r_ack  <= 1'b0;
            r_at   <= 1'b1;
        end else begin
            r_tgt <= w_tgt_nxt;
            r_cur <= w_cur_nxt;
            r_ack <= target_valid;
            r_at  <= (w_cur_nxt == w_tgt_nxt);
            if (w_launch) begin
                r_duty <= w_step;
            end
        end
    end

    assign duty       = r_duty;
    assign ready      = (r_state == WAIT_DONE);
    assign busy       = (r_state == WAIT_DONE);
    assign target_ack = r_ack;
    assign at_target  = r_at;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed table, ramp sequences and a randomized model check.
module tb_pwm_duty_ramp;

    localparam int R    = 8;
    localparam int FULL = 256;
    localparam int DMAX = 230;
`ifdef PWM_DUTY_CLAMP_EN
    localparam int SAT300 = DMAX;
`else
    localparam int SAT300 = FULL;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [R:0] target = '0;
    logic       target_valid = 1'b0;
    logic       target_ack;
    logic [R:0] step_size = '0;
    logic [R:0] duty;
    logic       ready;
    logic       done = 1'b0;
    logic       busy;
    logic       at_target;

    int vectors = 0;
    int miscompares = 0;

    int m_tgt, m_cur, m_duty;
    bit m_pend, m_ack;

    pwm_duty_ramp #(
        .R(R),
        .DUTY_MAX(DMAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .target(target),
        .target_valid(target_valid), .target_ack(target_ack), .step_size(step_size),
        .duty(duty), .ready(ready), .done(done), .busy(busy), .at_target(at_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en, tv; int t, st; logic dn;
        int duty; logic rdy, busy, ack, at;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int t);
        int s;
        s = (t > FULL) ? FULL : t;
`ifdef PWM_DUTY_CLAMP_EN
        if (s > DMAX) s = DMAX;
`endif
        return s;
    endfunction

    function automatic int next_duty(input int c, input int g, input int s);
        if (s == 0) return g;
        if (g > c) return (c + s < g) ? c + s : g;
        return (c - s > g) ? c - s : g;
    endfunction

    task automatic model_reset();
        m_tgt = 0; m_cur = 0; m_duty = 0; m_pend = 0; m_ack = 0;
    endtask

    task automatic model_edge(input bit en, input bit tv, input int t, input int st, input bit dn);
        if (m_pend) begin
            if (dn) begin
                m_cur  = m_duty;
                m_pend = 0;
            end
        end else if (en && m_cur != m_tgt) begin
            m_duty = next_duty(m_cur, m_tgt, st);
            m_pend = 1;
        end
        m_ack = tv;
        if (tv) m_tgt = sat(t);
    endtask

    task automatic check_model();
        chk("duty", int'(duty), m_duty);
        chk("ready", int'(ready), int'(m_pend));
        chk("busy", int'(busy), int'(m_pend));
        chk("target_ack", int'(target_ack), int'(m_ack));
        chk("at_target", int'(at_target), int'(m_cur == m_tgt));
    endtask

    task automatic cyc(input bit en, input bit tv, input int t, input int st, input bit dn);
        enable = en; target_valid = tv; target = t[R:0]; step_size = st[R:0]; done = dn;
        @(posedge clk);
        model_edge(en, tv, t, st, dn);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 0;
        enable = 0; target_valid = 0; done = 0;
        #1;
        chk("rst_duty", int'(duty), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(target_ack), 0);
        chk("rst_at_target", int'(at_target), 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        model_reset();
    endtask

    // Waits for the next offered update, checks its value, holds it 4 cycles, then pulses done.
    task automatic expect_update(input int st, input int exp_duty, input int inj);
        int k;
        k = 0;
        while (!ready && k < 10) begin
            cyc(1, 0, 0, st, 0);
            k++;
        end
        chk("ramp_ready_seen", int'(ready), 1);
        chk("ramp_duty", int'(duty), exp_duty);
        for (int h = 0; h < 4; h++) begin
            cyc(h[0], (h == 1) && (inj >= 0), inj, (h * 17) & 8'hFF, 0);
        end
        chk("ramp_hold_duty", int'(duty), exp_duty);
        cyc(1, 0, 0, st, 1);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 300, 0, 1'b0,  0,          1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 0,   0, 1'b1,  0,          1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 0,   0, 1'b0,  SAT300,     1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 10,  5, 1'b0,  SAT300,     1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 0,   5, 1'b1,  SAT300,     1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 0,   5, 1'b0,  SAT300 - 5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 0,   0, 1'b1,  SAT300 - 5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 0,   0, 1'b0,  10,         1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 0,   0, 1'b1,  10,         1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 0,   0, 1'b0,  10,         1'b0, 1'b0, 1'b0, 1'b1};

        model_reset();
        do_reset();
        #1;
        check_model();

        foreach (tbl[i]) begin
            cyc(tbl[i].en, tbl[i].tv, tbl[i].t, tbl[i].st, tbl[i].dn);
            chk($sformatf("tbl%0d_duty", i), int'(duty), tbl[i].duty);
            chk($sformatf("tbl%0d_ready", i), int'(ready), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_ack", i), int'(target_ack), int'(tbl[i].ack));
            chk($sformatf("tbl%0d_at", i), int'(at_target), int'(tbl[i].at));
        end

        // Ramp up 0 -> 100 in steps of 30.
        do_reset();
        cyc(1, 1, 100, 30, 0);
        expect_update(30, 30, -1);
        expect_update(30, 60, -1);
        expect_update(30, 90, -1);
        expect_update(30, 100, -1);
        chk("ramp_up_at_target", int'(at_target), 1);

        // Ramp down 100 -> 0 in steps of 40, no underflow.
        cyc(1, 1, 0, 40, 0);
        expect_update(40, 60, -1);
        expect_update(40, 20, -1);
        expect_update(40, 0, -1);
        chk("ramp_dn_at_target", int'(at_target), 1);

        // step 0 jumps straight to target.
        cyc(1, 1, 200, 0, 0);
        expect_update(0, 200, -1);
        repeat (3) cyc(1, 0, 0, 0, 0);
        chk("jump_ready_idle", int'(ready), 0);
        chk("jump_at_target", int'(at_target), 1);

        // Target change while 90 is in flight.
        do_reset();
        cyc(1, 1, 100, 30, 0);
        expect_update(30, 30, -1);
        expect_update(30, 60, -1);
        expect_update(30, 90, 50);
        expect_update(40, 50, -1);
        chk("retarget_at_target", int'(at_target), 1);

        // Reset while an update is pending discards it.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("pre_reset_ready", int'(ready), 1);
        do_reset();
        cyc(0, 0, 0, 0, 1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit en, tv, dn;
            int t, st;
            en = ($urandom_range(0, 3) != 0);
            tv = ($urandom_range(0, 9) == 0);
            dn = ($urandom_range(0, 2) == 0);
            t  = $urandom_range(0, 511);
            st = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 511);
            if ($urandom_range(0, 1) == 1) st = $urandom_range(1, 40);
            cyc(en, tv, t, st, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

Interface
REQ-001 Parameter R, 8: duty width is R+1 bits; full-on duty = 2^R.
REQ-002 Parameter DUTY_MAX, 2^R: clamp ceiling, used only when PWM_DUTY_CLAMP_EN is defined.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high permits new duty updates to start.
REQ-006 target  input  R+1  requested final duty.
REQ-007 target_valid  input  1  target present this cycle.
REQ-008 target_ack  output  1  one-cycle pulse: target captured.
REQ-009 step_size  input  R+1  max duty change per PWM update; 0 = jump.
REQ-010 duty  output  R+1  duty offered to the downstream PWM stage.
REQ-011 ready  output  1  duty update pending; held until done.
REQ-012 done  input  1  downstream pulse: offered duty now in effect.
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 at_target  output  1  current applied duty equals captured target.

Function
REQ-015 Registers: tgt_reg (captured target), cur_reg (last applied duty), duty (offered), FSM state IDLE/WAIT_DONE.
REQ-016 target_valid high in any state: tgt_reg <= saturated target next edge; target_ack = 1 the following cycle only.
REQ-017 Saturation: target > 2^R is stored as 2^R.
REQ-018 IDLE, enable=1, cur_reg != tgt_reg: next edge -> WAIT_DONE, ready=1, duty = next step.
REQ-019 Next step: up = min(cur+step_size, tgt); down = max(cur-step_size, tgt); computed in R+2 bits; never overshoots or wraps.
REQ-020 step_size = 0: next step = tgt_reg (single jump).
REQ-021 WAIT_DONE: duty and ready stable regardless of target_valid, step_size or enable changes.
REQ-022 WAIT_DONE with done=1: next edge cur_reg <= duty, ready=0, -> IDLE; earliest next ready is one cycle later.
REQ-023 done outside WAIT_DONE is ignored.
REQ-024 Target change during WAIT_DONE: in-flight update completes unchanged; next step computed from new tgt_reg.
REQ-025 enable low: no new WAIT_DONE entry; in-flight WAIT_DONE still completes on done.
REQ-026 at_target = (cur_reg == tgt_reg), registered; busy = (state == WAIT_DONE).

Reset
REQ-027 reset_n low: state IDLE, tgt_reg=0, cur_reg=0, duty=0, ready=0, target_ack=0, busy=0, at_target=1.
REQ-028 Reset during WAIT_DONE drops ready immediately; pending update discarded.

Configuration
REQ-029 Macro PWM_DUTY_CLAMP_EN defined: captured target limited to min(target, DUTY_MAX, 2^R).
REQ-030 Macro undefined: only the 2^R saturation applies; DUTY_MAX unused.

Structure
REQ-031 Shared package pwm_pkg holds the FSM state enum and the default R constant.
REQ-032 One combinational sub-module, duty_stepper, computes the next step (REQ-019/020); the rest is the top FSM.

Verification (R=8)
REQ-033 Reset released -> duty=0, ready=0, at_target=1, busy=0.
REQ-034 target=100, step=30, done 5 cycles after each ready -> duty 30,60,90,100 in sequence, each held with ready until done; at_target=1 after the 4th done.
REQ-035 From 100, target=0, step=40 -> duty 60,20,0; no underflow.
REQ-036 step=0, target=200 -> a single update with duty=200.
REQ-037 target=50 captured while WAIT_DONE offers 90 (ramping to 100) -> 90 applied unchanged, then 50 next (step 40).
REQ-038 target=300 -> saturates to 256; with PWM_DUTY_CLAMP_EN and DUTY_MAX=230 -> 230.
